// File: rtl/time_ref_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_ref_pkg
// Brief    : Shared types and helpers for the common time base.
// Revision : 1.0 - initial release
// ============================================================================
package time_ref_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLDOVER = 2'd3
    } lock_state_e;

    localparam int c_ts_w_default = 64;

    // The watchdog has to hold SYNC_TIMEOUT-1 without overflowing.
    function automatic int wdog_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_capture_ch.sv
`default_nettype none
// ============================================================================
// Module   : ts_capture_ch
// Brief    : One timestamp capture channel with valid/ready and overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module ts_capture_ch #(
    parameter int TS_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ev_strobe,
    input  logic            ts_ready,
    input  logic [TS_W-1:0] t_now,
    input  logic            overrun_clr,
    output logic            ts_valid,
    output logic [TS_W-1:0] ts_data,
    output logic            ts_overrun
);

    logic            r_valid;
    logic [TS_W-1:0] r_data;
    logic            r_overrun;
    logic            w_accept;

    // A full register frees up in the same cycle the consumer takes it.
    assign w_accept = ~r_valid | ts_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (ev_strobe) begin
                if (w_accept) begin
                    r_data  <= t_now;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && ts_ready) begin
                r_valid <= 1'b0;
            end

            if (ev_strobe && !w_accept) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign ts_valid   = r_valid;
    assign ts_data    = r_data;
    assign ts_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/time_reference_mc.sv
`default_nettype none
// ============================================================================
// Module   : time_reference_mc
// Brief    : Common time base with sync/prescaled counting, lock watchdog and
//            per-sensor capture. Define TIME_REF_SYNC_STAGES_EN to insert a
//            two-flop synchroniser on sync_signal.
// Revision : 1.0 - initial release
// ============================================================================
module time_reference_mc
    import time_ref_pkg::*;
#(
    parameter int TS_W         = c_ts_w_default,
    parameter int NUM_CH       = 4,
    parameter int PRESC_W      = 8,
    parameter int SYNC_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [PRESC_W-1:0]     presc_div,
    input  logic                   sync_signal,
    input  logic                   load_en,
    input  logic [TS_W-1:0]        load_value,
    output logic [TS_W-1:0]        t_common,
    output logic                   t_wrap,
    output logic [1:0]             lock_state,
    input  logic [NUM_CH-1:0]      ev_strobe,
    output logic [NUM_CH-1:0]      ts_valid,
    input  logic [NUM_CH-1:0]      ts_ready,
    output logic [NUM_CH*TS_W-1:0] ts_data,
    output logic [NUM_CH-1:0]      ts_overrun,
    input  logic                   overrun_clr
);

    localparam int c_wd_w = wdog_width(SYNC_TIMEOUT);

    logic               w_sync_in;
    logic               r_sync_q;
    logic               w_sync_edge;
    logic               w_tick;
    logic [PRESC_W-1:0] r_pcnt;
    logic [TS_W-1:0]    r_t_common;
    logic               r_t_wrap;
    lock_state_e        r_state;
    lock_state_e        w_state_next;
    logic [c_wd_w-1:0]  r_wdog;
    logic [c_wd_w-1:0]  w_wdog_next;

`ifdef TIME_REF_SYNC_STAGES_EN
    logic r_sync_meta;
    logic r_sync_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync_s    <= 1'b0;
        end else begin
            r_sync_meta <= sync_signal;
            r_sync_s    <= r_sync_meta;
        end
    end

    assign w_sync_in = r_sync_s;
`else
    assign w_sync_in = sync_signal;
`endif

    assign w_sync_edge = w_sync_in & ~r_sync_q;
    assign w_tick      = mode ? (r_pcnt == presc_div) : w_sync_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q   <= 1'b0;
            r_pcnt     <= '0;
            r_t_common <= '0;
            r_t_wrap   <= 1'b0;
        end else begin
            r_sync_q <= w_sync_in;
            r_t_wrap <= 1'b0;

            if (load_en || !mode || r_state == IDLE || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end

            // Load has priority over counting so PPS discipline is exact.
            if (load_en) begin
                r_t_common <= load_value;
            end else if (w_tick && r_state != IDLE) begin
                r_t_common <= r_t_common + TS_W'(1);
                r_t_wrap   <= &r_t_common;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wdog  <= w_wdog_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wdog_next  = '0;
        if (enable) begin
            unique case (r_state)
                IDLE:     w_state_next = ACQUIRE;
                ACQUIRE:  if (w_sync_edge) w_state_next = LOCKED;
                LOCKED: begin
                    if (!w_sync_edge) begin
                        if (r_wdog == c_wd_w'(SYNC_TIMEOUT - 1)) begin
                            w_state_next = HOLDOVER;
                        end else begin
                            w_wdog_next = r_wdog + c_wd_w'(1);
                        end
                    end
                end
                HOLDOVER: if (w_sync_edge) w_state_next = LOCKED;
                default:  w_state_next = IDLE;
            endcase
        end else begin
            w_state_next = IDLE;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ts_capture_ch #(
                .TS_W (TS_W)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .ev_strobe   (ev_strobe[gi]),
                .ts_ready    (ts_ready[gi]),
                .t_now       (r_t_common),
                .overrun_clr (overrun_clr),
                .ts_valid    (ts_valid[gi]),
                .ts_data     (ts_data[gi*TS_W +: TS_W]),
                .ts_overrun  (ts_overrun[gi])
            );
        end
    endgenerate

    assign t_common   = r_t_common;
    assign t_wrap     = r_t_wrap;
    assign lock_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_time_reference_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_reference_mc
// Brief    : Randomised self-checking bench against a behavioural time-base model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_reference_mc;

    localparam int c_ts_w = 16;
    localparam int c_nch  = 3;
    localparam int c_pw   = 3;
    localparam int c_tout = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic                    mode;
    logic [c_pw-1:0]         presc_div;
    logic                    sync_signal;
    logic                    load_en;
    logic [c_ts_w-1:0]       load_value;
    logic [c_ts_w-1:0]       t_common;
    logic                    t_wrap;
    logic [1:0]              lock_state;
    logic [c_nch-1:0]        ev_strobe;
    logic [c_nch-1:0]        ts_valid;
    logic [c_nch-1:0]        ts_ready;
    logic [c_nch*c_ts_w-1:0] ts_data;
    logic [c_nch-1:0]        ts_overrun;
    logic                    overrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state (state: 0 idle, 1 acquire, 2 locked, 3 holdover)
    int unsigned m_t;
    bit          m_wrap;
    int          m_state;
    int          m_quiet;
    int          m_phase;
    bit          m_prev, m_s1, m_s2;
    bit          m_valid [c_nch];
    int unsigned m_data  [c_nch];
    bit          m_ovr   [c_nch];

    time_reference_mc #(
        .TS_W(c_ts_w), .NUM_CH(c_nch), .PRESC_W(c_pw), .SYNC_TIMEOUT(c_tout)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .presc_div(presc_div), .sync_signal(sync_signal), .load_en(load_en),
        .load_value(load_value), .t_common(t_common), .t_wrap(t_wrap),
        .lock_state(lock_state), .ev_strobe(ev_strobe), .ts_valid(ts_valid),
        .ts_ready(ts_ready), .ts_data(ts_data), .ts_overrun(ts_overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_wrap = 0; m_state = 0; m_quiet = 0; m_phase = 0;
        m_prev = 0; m_s1 = 0; m_s2 = 0;
        for (int i = 0; i < c_nch; i++) begin
            m_valid[i] = 0; m_data[i] = 0; m_ovr[i] = 0;
        end
    endtask

    // Called just after a rising edge; inputs still hold the sampled values.
    task automatic model_advance();
        bit          sy, edge_seen, tick;
        int unsigned nt;
        bit          nw;
        int          nph, nst, nq;
        sy = sync_signal;
`ifdef TIME_REF_SYNC_STAGES_EN
        sy = m_s2;
`endif
        edge_seen = sy && !m_prev;
        tick = mode ? (m_phase == int'(presc_div)) : edge_seen;

        nw = 0;
        nt = m_t;
        if (load_en) nt = load_value;
        else if (tick && m_state != 0) begin
            nt = (m_t + 1) % (1 << c_ts_w);
            nw = (m_t == (1 << c_ts_w) - 1);
        end
        nph = (load_en || !mode || m_state == 0 || tick) ? 0 : m_phase + 1;

        nst = m_state;
        nq  = 0;
        if (!enable) nst = 0;
        else case (m_state)
            0: nst = 1;
            1: if (edge_seen) nst = 2;
            2: if (!edge_seen) begin
                   if (m_quiet + 1 >= c_tout) nst = 3;
                   else nq = m_quiet + 1;
               end
            default: if (edge_seen) nst = 2;
        endcase

        for (int i = 0; i < c_nch; i++) begin
            bit full_blocked;
            full_blocked = m_valid[i] && !ts_ready[i];
            if (ev_strobe[i]) begin
                if (full_blocked) m_ovr[i] = 1;
                else begin
                    m_data[i]  = m_t;
                    m_valid[i] = 1;
                end
            end else begin
                if (m_valid[i] && ts_ready[i]) m_valid[i] = 0;
            end
            if (!(ev_strobe[i] && full_blocked) && overrun_clr) m_ovr[i] = 0;
        end

        m_t = nt; m_wrap = nw; m_phase = nph; m_state = nst; m_quiet = nq;
        m_s2 = m_s1; m_s1 = sync_signal; m_prev = sy;
    endtask

    task automatic compare_all();
        logic [c_nch*c_ts_w-1:0] ed;
        logic [c_nch-1:0]        ev, eo;
        for (int i = 0; i < c_nch; i++) begin
            ed[i*c_ts_w +: c_ts_w] = m_data[i][c_ts_w-1:0];
            ev[i] = m_valid[i];
            eo[i] = m_ovr[i];
        end
        check_val("t_common",   64'(t_common),   64'(m_t[c_ts_w-1:0]));
        check_val("t_wrap",     64'(t_wrap),     64'(m_wrap));
        check_val("lock_state", 64'(lock_state), 64'(m_state));
        check_val("ts_valid",   64'(ts_valid),   64'(ev));
        check_val("ts_data",    64'(ts_data),    64'(ed));
        check_val("ts_overrun", 64'(ts_overrun), 64'(eo));
    endtask

    task automatic run_cycle(input bit en, input bit md, input logic [c_pw-1:0] pd,
                             input bit sy, input bit ld, input logic [c_ts_w-1:0] lv,
                             input logic [c_nch-1:0] ev, input logic [c_nch-1:0] rd,
                             input bit oc);
        @(negedge clk);
        enable = en; mode = md; presc_div = pd; sync_signal = sy;
        load_en = ld; load_value = lv; ev_strobe = ev; ts_ready = rd;
        overrun_clr = oc;
        @(posedge clk);
        #1;
        model_advance();
        compare_all();
    endtask

    initial begin
        bit                 sy;
        bit                 md;
        logic [c_pw-1:0]    pd;
        int                 sync_pct, rdy_pct;

        rst_n = 1'b0; enable = 0; mode = 0; presc_div = '0; sync_signal = 0;
        load_en = 0; load_value = '0; ev_strobe = '0; ts_ready = '0; overrun_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: sync-edge counting, then load near the top and wrap.
        sy = 0;
        for (int k = 0; k < 30; k++) begin
            sy = (k % 10) == 3 ? 1'b1 : ((k % 10) == 6 ? 1'b0 : sy);
            run_cycle(1, 0, '0, sy, 0, '0, '0, '0, 0);
        end
        run_cycle(1, 1, '0, 0, 1, 16'hFFFE, '0, '0, 0);
        repeat (4) run_cycle(1, 1, '0, 0, 0, '0, 3'b001, '0, 0);
        run_cycle(1, 1, '0, 0, 1, 16'h0007, '0, '0, 1);

        // Randomised segments with fixed mode/prescaler per segment.
        for (int seg = 0; seg < 24; seg++) begin
            md       = $urandom_range(0, 1);
            pd       = c_pw'($urandom_range(0, (1 << c_pw) - 1));
            sync_pct = (seg % 4 == 1) ? 0 : $urandom_range(5, 50);
            rdy_pct  = (seg % 3 == 0) ? 10 : 60;
            run_cycle(1, 0, pd, sy, 0, '0, '0, '0, 0);
            if (seg == 12) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge clk);
                rst_n = 1'b1;
                sy = 0;
            end
            for (int c = 0; c < 120; c++) begin
                logic [c_nch-1:0]  ev, rd;
                logic [c_ts_w-1:0] lv;
                bit                ld;
                if ($urandom_range(0, 99) < sync_pct) sy = ~sy;
                for (int i = 0; i < c_nch; i++) begin
                    ev[i] = $urandom_range(0, 5) == 0;
                    rd[i] = $urandom_range(0, 99) < rdy_pct;
                end
                ld = $urandom_range(0, 39) == 0;
                lv = $urandom_range(0, 1) ? 16'hFFFF - c_ts_w'($urandom_range(0, 3))
                                          : c_ts_w'($urandom);
                run_cycle($urandom_range(0, 99) != 0, md, pd, sy, ld, lv, ev, rd,
                          $urandom_range(0, 24) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
